// File: rtl/interval_timer_ctrl_pkg.sv
// Shared constants for the interval timer controller and its counter datapath.
package interval_timer_ctrl_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned RPT_W_DEF = 8;

   // Controller states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/interval_timer_ctrl_count_dp.sv
// Loadable WIDTH-bit up-counter; load has priority over enable.
module timer_count_dp #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // Counter register, wraps from all-ones to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_data;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller: sequences the counter datapath,
// detects the terminal value, emits per-period ticks and a final done.
// repeat_cnt carries the repeat count (0 = run until stop).
module interval_timer_ctrl
   import interval_timer_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned RPT_W = RPT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] term_val,
   input  logic [RPT_W-1:0] repeat_cnt,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic [RPT_W-1:0] periods
);

   logic [1:0]       state,       state_nxt;
   logic [WIDTH-1:0] start_r,     start_r_nxt;
   logic [WIDTH-1:0] term_r,      term_r_nxt;
   logic [RPT_W-1:0] rpt_r,       rpt_r_nxt;
   logic [RPT_W-1:0] periods_nxt;
   logic             busy_nxt;
   logic             tick_nxt;
   logic             done_nxt;

   logic             load_c;
   logic             en_c;
   logic             terminal_c;
   logic             last_c;
   logic [RPT_W-1:0] periods_inc_c;

   timer_count_dp #(
      .WIDTH (WIDTH)
   ) u_count_dp (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c),
      .load_data (start_r),
      .en        (en_c),
      .count     (count)
   );

   // Terminal compare, last-period detect and saturating period increment
   always_comb begin
      terminal_c    = (count == term_r);
      last_c        = (rpt_r != '0) && ((periods + RPT_W'(1)) == rpt_r);
      periods_inc_c = (&periods) ? periods : (periods + RPT_W'(1));
   end

   // Next-state, datapath controls and next output values
   always_comb begin
      state_nxt   = state;
      start_r_nxt = start_r;
      term_r_nxt  = term_r;
      rpt_r_nxt   = rpt_r;
      periods_nxt = periods;
      tick_nxt    = 1'b0;
      done_nxt    = 1'b0;
      load_c      = 1'b0;
      en_c        = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               start_r_nxt = start_val;
               term_r_nxt  = term_val;
               rpt_r_nxt   = repeat_cnt;
               periods_nxt = '0;
               state_nxt   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else begin
               load_c    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // stop wins over a coincident terminal cycle
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (terminal_c) begin
               tick_nxt    = 1'b1;
               periods_nxt = periods_inc_c;
               if (last_c) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  load_c = 1'b1;
               end
            end else begin
               en_c = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

   // State, captured configuration and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         start_r <= '0;
         term_r  <= '0;
         rpt_r   <= '0;
         periods <= '0;
         busy    <= 1'b0;
         tick    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_r <= start_r_nxt;
         term_r  <= term_r_nxt;
         rpt_r   <= rpt_r_nxt;
         periods <= periods_nxt;
         busy    <= busy_nxt;
         tick    <= tick_nxt;
         done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: directed scenarios plus
// randomized traffic against a period-position reference model.
module tb_interval_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic [7:0] start_val;
   logic [7:0] term_val;
   logic [7:0] repeat_cnt;
   logic [7:0] count;
   logic       busy;
   logic       tick;
   logic       done;
   logic [7:0] periods;

   always #5 clk = ~clk;

   interval_timer_ctrl #(
      .WIDTH (8),
      .RPT_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .start_val  (start_val),
      .term_val   (term_val),
      .repeat_cnt (repeat_cnt),
      .count      (count),
      .busy       (busy),
      .tick       (tick),
      .done       (done),
      .periods    (periods)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: phase 0=idle 1=load 2=run; pos = offset within period
   int m_phase   = 0;
   int m_pos     = 0;
   int m_len     = 1;
   int m_sv      = 0;
   int m_tv      = 0;
   int m_rp      = 0;
   int m_count   = 0;
   int m_periods = 0;
   int m_tick    = 0;
   int m_done    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_phase = 0; m_pos = 0; m_len = 1;
         m_sv = 0; m_tv = 0; m_rp = 0;
         m_count = 0; m_periods = 0; m_tick = 0; m_done = 0;
      end else begin
         m_tick = 0;
         m_done = 0;
         if (m_phase == 0) begin
            if (start) begin
               m_sv = int'(start_val);
               m_tv = int'(term_val);
               m_rp = int'(repeat_cnt);
               m_len = ((m_tv - m_sv) & 255) + 1;
               m_periods = 0;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (stop) m_phase = 0;
            else begin
               m_count = m_sv;
               m_pos = 0;
               m_phase = 2;
            end
         end else begin
            if (stop) m_phase = 0;
            else if (m_pos == m_len - 1) begin
               m_tick = 1;
               if (!(m_rp == 0 && m_periods == 255)) m_periods = m_periods + 1;
               if (m_rp != 0 && m_periods == m_rp) begin
                  m_done = 1;
                  m_phase = 0;
               end else begin
                  m_pos = 0;
                  m_count = m_sv;
               end
            end else begin
               m_pos = m_pos + 1;
               m_count = (m_sv + m_pos) & 255;
            end
         end
      end
   endtask

   // One clock: advance model with the inputs the DUT samples, then compare
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("count",   32'(count),   32'(m_count));
      check("busy",    32'(busy),    32'(m_phase != 0));
      check("tick",    32'(tick),    32'(m_tick));
      check("done",    32'(done),    32'(m_done));
      check("periods", 32'(periods), 32'(m_periods));
   endtask

   task automatic do_start(input int sv, input int tv, input int rp);
      start_val  = 8'(sv);
      term_val   = 8'(tv);
      repeat_cnt = 8'(rp);
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   // Cycles from now until tick is seen (bounded); -1 on timeout
   task automatic wait_tick(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (tick) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic one_shot_5_8();
      int c;
      do_start(5, 8, 1);
      wait_tick(c);
      check("oneshot_latency", 32'(c), 32'd5);
      check("oneshot_done",    32'(done), 32'd1);
      check("oneshot_count",   32'(count), 32'd8);
      step();
      check("oneshot_idle_busy",  32'(busy),  32'd0);
      check("oneshot_hold_count", 32'(count), 32'd8);
      check("oneshot_single_tick", 32'(tick), 32'd0);
   endtask

   initial begin
      int c1, c2;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      start_val = '0; term_val = '0; repeat_cnt = '0;
      step();
      step();
      rst = 1'b0;
      check("reset_count", 32'(count), 32'd0);
      check("reset_busy",  32'(busy),  32'd0);

      // 1: reset mid-run
      do_start(5, 20, 0);
      repeat (6) step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_run_count",   32'(count),   32'd0);
      check("rst_run_busy",    32'(busy),    32'd0);
      check("rst_run_periods", 32'(periods), 32'd0);
      repeat (3) step();

      // 2: one-shot
      one_shot_5_8();

      // 3: wrap-around, two periods
      do_start(250, 3, 2);
      wait_tick(c1);
      check("wrap_first_tick", 32'(c1), 32'd11);
      check("wrap_first_not_done", 32'(done), 32'd0);
      wait_tick(c2);
      check("wrap_spacing", 32'(c2), 32'd10);
      check("wrap_done",    32'(done), 32'd1);
      check("wrap_periods", 32'(periods), 32'd2);
      step();

      // 4: free-running single-cycle period, then stop
      do_start(7, 7, 0);
      step();
      repeat (8) begin
         step();
         check("free_tick", 32'(tick), 32'd1);
      end
      check("free_periods", 32'(periods), 32'd8);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("free_stop_tick", 32'(tick), 32'd0);
      check("free_stop_done", 32'(done), 32'd0);
      check("free_stop_busy", 32'(busy), 32'd0);
      repeat (3) step();

      // 5: stop on terminal cycle, start while busy ignored
      do_start(0, 2, 3);
      start = 1'b1; start_val = 8'd99; term_val = 8'd200; repeat_cnt = 8'd1;
      step();
      start = 1'b0;
      step();
      step();
      check("stopterm_count", 32'(count), 32'd2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stopterm_tick",    32'(tick),    32'd0);
      check("stopterm_periods", 32'(periods), 32'd0);
      check("stopterm_busy",    32'(busy),    32'd0);
      check("stopterm_hold",    32'(count),   32'd2);
      repeat (2) step();

      // 6: reset during LOAD, then a fresh one-shot
      do_start(5, 8, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_load_count", 32'(count), 32'd0);
      repeat (4) begin
         step();
         check("rst_load_no_tick", 32'(tick), 32'd0);
      end
      one_shot_5_8();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 5) == 0);
         stop  = ($urandom_range(0, 39) == 0);
         start_val = 8'($urandom);
         if ($urandom_range(0, 9) == 0) term_val = 8'($urandom);
         else term_val = start_val + 8'($urandom_range(0, 15));
         repeat_cnt = 8'($urandom_range(0, 4));
         step();
      end
      rst = 1'b0; start = 1'b0; stop = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
